// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcodes,
// R-type funct codes, ALU function codes and the ALUOp codes.
package mc_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND   = 3'b000;
    localparam logic [2:0] ALU_OR    = 3'b001;
    localparam logic [2:0] ALU_ADD   = 3'b010;
    localparam logic [2:0] ALU_UNDEF = 3'b011;
    localparam logic [2:0] ALU_SUB   = 3'b110;
    localparam logic [2:0] ALU_SLT   = 3'b111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU decoder: maps ALUOp and the R-type funct field onto the
// 3-bit alu32 function code.
module alu_decoder
    import mc_pkg::*;
(
    input  logic [1:0] ALUOp,
    input  logic [5:0] funct,
    output logic [2:0] ALUControl
);

    // ALUOp 11 is unused by the FSM and falls back to add.
    always_comb begin
        ALUControl = ALU_ADD;
        case (ALUOp)
            ALUOP_SUB: ALUControl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  ALUControl = ALU_ADD;
                    FN_SUB:  ALUControl = ALU_SUB;
                    FN_AND:  ALUControl = ALU_AND;
                    FN_OR:   ALUControl = ALU_OR;
                    FN_SLT:  ALUControl = ALU_SLT;
                    default: ALUControl = ALU_UNDEF;
                endcase
            end
            default: ALUControl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle control unit: Moore FSM sequencing fetch/decode/execute/writeback
// plus the ALU decoder and the branch-qualified PC enable.
module mc_controller
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       PCEn,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic [2:0] ALUControl,
    output logic [3:0] state_o
);

    state_t     state, next_state;
    logic [1:0] aluop;
    logic       pcwrite, branch, irwrite_s, regwrite_s, memwrite_s;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= FETCH;
        else        state <= next_state;
    end

    always_comb begin
        next_state = FETCH;
        case (state)
            FETCH:  next_state = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_RTYPE:     next_state = EXECUTE;
                    OP_BEQ:       next_state = BRANCH;
                    OP_ADDI:      next_state = ADDIEX;
                    OP_J:         next_state = JUMP;
                    default:      next_state = FETCH;
                endcase
            end
            MEMADR:  next_state = (op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:   next_state = MEMWB;
            EXECUTE: next_state = ALUWB;
            ADDIEX:  next_state = ADDIWB;
            default: next_state = FETCH;
        endcase
    end

    // Moore output decode; anything not named for a state stays at 0.
    always_comb begin
        IorD       = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        PCSrc      = 2'b00;
        aluop      = ALUOP_ADD;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        irwrite_s  = 1'b0;
        regwrite_s = 1'b0;
        memwrite_s = 1'b0;
        case (state)
            FETCH: begin
                ALUSrcB   = 2'b01;
                irwrite_s = 1'b1;
                pcwrite   = 1'b1;
            end
            DECODE:  ALUSrcB = 2'b11;
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            MEMRD:   IorD = 1'b1;
            MEMWB: begin
                MemtoReg   = 1'b1;
                regwrite_s = 1'b1;
            end
            MEMWR: begin
                IorD       = 1'b1;
                memwrite_s = 1'b1;
            end
            EXECUTE: begin
                ALUSrcA = 1'b1;
                aluop   = ALUOP_FUNCT;
            end
            ALUWB: begin
                RegDst     = 1'b1;
                regwrite_s = 1'b1;
            end
            BRANCH: begin
                ALUSrcA = 1'b1;
                aluop   = ALUOP_SUB;
                PCSrc   = 2'b01;
                branch  = 1'b1;
            end
            ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            ADDIWB:  regwrite_s = 1'b1;
            JUMP: begin
                PCSrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: ;
        endcase
    end

    // Gating with reset keeps FETCH from writing the PC or IR while held in reset.
    assign PCEn     = (pcwrite | (branch & zero)) & reset;
    assign IRWrite  = irwrite_s & reset;
    assign RegWrite = regwrite_s & reset;
    assign MemWrite = memwrite_s & reset;
    assign state_o  = state;

    alu_decoder u_alu_decoder (
        .ALUOp      (aluop),
        .funct      (funct),
        .ALUControl (ALUControl)
    );

endmodule
